// File: rtl/divider_iter_pkg.sv
// Shared definitions for the iterative divider.
// Holds the M-extension divide opcodes (also used by the ALU and decoder),
// the FSM state encoding, and small opcode decode helpers.
`ifndef DIVIDER_ITER_PKG_SV
`define DIVIDER_ITER_PKG_SV

`ifndef ALU_OP_DIV
`define ALU_OP_DIV  4'b1100
`endif
`ifndef ALU_OP_DIVU
`define ALU_OP_DIVU 4'b1101
`endif
`ifndef ALU_OP_REM
`define ALU_OP_REM  4'b1110
`endif
`ifndef ALU_OP_REMU
`define ALU_OP_REMU 4'b1111
`endif

package divider_iter_pkg;

  localparam logic [3:0] OP_DIV  = `ALU_OP_DIV;
  localparam logic [3:0] OP_DIVU = `ALU_OP_DIVU;
  localparam logic [3:0] OP_REM  = `ALU_OP_REM;
  localparam logic [3:0] OP_REMU = `ALU_OP_REMU;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_PREP = 2'd1;
  localparam logic [1:0] STATE_CALC = 2'd2;
  localparam logic [1:0] STATE_FIX  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_PREP = STATE_PREP,
    ST_CALC = STATE_CALC,
    ST_FIX  = STATE_FIX
  } div_state_e;

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [3:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_known(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

`endif

// File: rtl/divider_iter_restore_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor and keep or restore.
// Purely combinational so it can be chained for an unrolled variant.
module div_restore_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Trial subtract in XLEN+1 bits; the top bit of diff is the borrow.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[XLEN];
    rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/divider_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Flow: IDLE -> PREP (abs values, special-case flags) -> CALC (XLEN steps)
// -> FIX (signs, overrides, result strobe). kill_i aborts any operation.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// |a| < |b| skip CALC and finish two cycles after accept.
module divider_iter
  import divider_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [3:0]      div_op_i,
  input  logic            div_valid_i,
  output logic            div_ready_o,
  input  logic            kill_i,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            busy_o
);

  localparam int              CW   = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state;

  logic [XLEN-1:0] a_q, b_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] dividend_q, divisor_q, rem_q, quot_q;
  logic [CW-1:0]   count_q;
  logic            neg_quot_q, neg_rem_q, div_zero_q, ovf_q;

  logic            accept;
  logic            signed_op;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            b_zero, a_ovf;
  logic [XLEN-1:0] rem_next;
  logic            q_bit;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_result;

  assign div_ready_o = (state == ST_IDLE);
  assign busy_o      = ~div_ready_o;
  assign accept      = div_valid_i & div_ready_o & ~kill_i;

  // PREP-stage decode of the latched operands.
  always_comb begin
    signed_op = op_is_signed(op_q);
    a_abs     = (signed_op && a_q[XLEN-1]) ? -a_q : a_q;
    b_abs     = (signed_op && b_q[XLEN-1]) ? -b_q : b_q;
    b_zero    = (b_q == '0);
    a_ovf     = signed_op && (a_q == MIN_NEG) && (b_q == '1);
  end

`ifdef DIV_EARLY_OUT_EN
  logic early;
  // Operations whose answer is known without iterating.
  always_comb begin
    early = b_zero | a_ovf | (a_abs < b_abs);
  end
`endif

  div_restore_step #(.XLEN(XLEN)) u_step (
    .rem_in       (rem_q),
    .dividend_bit (dividend_q[XLEN-1]),
    .divisor      (divisor_q),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  // Sign correction, special-case overrides and op selection for FIX.
  always_comb begin
    quot_fix = neg_quot_q ? -quot_q : quot_q;
    rem_fix  = neg_rem_q  ? -rem_q  : rem_q;
    if (div_zero_q) begin
      quot_fix = '1;
      rem_fix  = a_q;
    end else if (ovf_q) begin
      quot_fix = a_q;
      rem_fix  = '0;
    end
    if (!op_is_known(op_q)) fix_result = '0;
    else if (op_is_rem(op_q)) fix_result = rem_fix;
    else                      fix_result = quot_fix;
  end

  // Datapath registers: operand capture, preparation and one step per CALC cycle.
  // NOTE: datapath registers are deliberately not reset; only the FSM and outputs need defined reset values.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (accept) begin
          a_q  <= operand_a_i;
          b_q  <= operand_b_i;
          op_q <= div_op_i;
        end
      end
      ST_PREP: begin
        dividend_q <= a_abs;
        divisor_q  <= b_abs;
        rem_q      <= '0;
        quot_q     <= '0;
        count_q    <= '0;
        neg_quot_q <= signed_op & (a_q[XLEN-1] ^ b_q[XLEN-1]);
        neg_rem_q  <= signed_op & a_q[XLEN-1];
        div_zero_q <= b_zero;
        ovf_q      <= a_ovf;
`ifdef DIV_EARLY_OUT_EN
        // |a| < |b|: quotient 0 and remainder |a|, sign restored in FIX.
        if (early) rem_q <= a_abs;
`endif
      end
      ST_CALC: begin
        rem_q      <= rem_next;
        quot_q     <= {quot_q[XLEN-2:0], q_bit};
        dividend_q <= dividend_q << 1;
        count_q    <= count_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Control FSM with registered result and strobe; synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      result_o       <= '0;
      result_valid_o <= 1'b0;
    end else begin
      result_valid_o <= 1'b0;
      if (state != ST_IDLE && kill_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (accept) state <= ST_PREP;
          ST_PREP: begin
`ifdef DIV_EARLY_OUT_EN
            state <= early ? ST_FIX : ST_CALC;
`else
            state <= ST_CALC;
`endif
          end
          ST_CALC: if (count_q == LAST) state <= ST_FIX;
          ST_FIX: begin
            result_o       <= fix_result;
            result_valid_o <= 1'b1;
            state          <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter (XLEN=32): directed cases, kill,
// mid-operation reset, back-to-back issue and randomized operations checked
// against an arithmetic reference model.
module tb_divider_iter;

  localparam logic [3:0] DIV  = 4'b1100;
  localparam logic [3:0] DIVU = 4'b1101;
  localparam logic [3:0] REM  = 4'b1110;
  localparam logic [3:0] REMU = 4'b1111;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  div_op;
  logic        div_valid, kill;
  logic        div_ready, result_valid, busy;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_result;

  divider_iter #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .operand_a_i    (operand_a),
    .operand_b_i    (operand_b),
    .div_op_i       (div_op),
    .div_valid_i    (div_valid),
    .div_ready_o    (div_ready),
    .kill_i         (kill),
    .result_o       (result),
    .result_valid_o (result_valid),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics with plain integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      DIV:  if (b == 0) return 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            else return 32'(sa / sb);
      REM:  if (b == 0) return a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            else return 32'(sa % sb);
      DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      REMU: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] op);
    longint ma, mb;
    bit sgn, early;
    sgn = (op == DIV) || (op == REM);
    ma  = sgn ? longint'(int'(a)) : longint'(a);
    mb  = sgn ? longint'(int'(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    early = (b == 0) || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) || (ma < mb);
    return (EARLY && early) ? 2 : 34;
  endfunction

  // Issue one request (called #1 after an edge with the DUT idle) and check it.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] exp, input string tag);
    int lat;
    check({tag, " ready"}, 64'(div_ready), 64'(1));
    operand_a = a; operand_b = b; div_op = op; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'(1));
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_latency(a, b, op)));
    check({tag, " result"}, 64'(result), 64'(exp));
    last_result = result;
    @(posedge clk); #1;
    check({tag, " strobe len"}, 64'(result_valid), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b0; div_valid = 1'b0; kill = 1'b0;
    operand_a = '0; operand_b = '0; div_op = DIV;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", 64'(div_ready), 64'(1));
    check("rst busy", 64'(busy), 64'(0));
    check("rst valid", 64'(result_valid), 64'(0));
    check("rst result", 64'(result), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-computed expectations.
    run_op(32'hFFFFFFF9, 32'd2, DIV, 32'hFFFFFFFD, "div neg");
    run_op(32'hFFFFFFF9, 32'd2, REM, 32'hFFFFFFFF, "rem neg");
    run_op(32'hFFFFFFFF, 32'h10, DIVU, 32'h0FFFFFFF, "divu");
    run_op(32'hFFFFFFFF, 32'h10, REMU, 32'h0000000F, "remu");
    run_op(32'h80000000, 32'hFFFFFFFF, DIV, 32'h80000000, "div ovf");
    run_op(32'h80000000, 32'hFFFFFFFF, REM, 32'h0, "rem ovf");
    run_op(32'd5, 32'd0, DIV, 32'hFFFFFFFF, "div by 0");
    run_op(32'd5, 32'd0, REM, 32'd5, "rem by 0");

    // Kill on the 10th CALC cycle: no strobe, result held, idle next cycle.
    operand_a = 32'h12345678; operand_b = 32'd3; div_op = DIVU; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill ready", 64'(div_ready), 64'(1));
    check("kill busy", 64'(busy), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("kill no strobe", 64'(seen), 64'(0));
    check("kill result held", 64'(result), 64'(last_result));
    run_op(32'd100, 32'd7, DIVU, 32'd14, "after kill");

    // Kill together with a request in IDLE discards the request.
    operand_a = 32'd50; operand_b = 32'd5; div_op = DIVU; div_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0; kill = 1'b0;
    check("idle kill ready", 64'(div_ready), 64'(1));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("idle kill no strobe", 64'(seen), 64'(0));

    // Reset mid-CALC returns outputs to reset values on that edge.
    operand_a = 32'd1000; operand_b = 32'd3; div_op = DIVU; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst valid", 64'(result_valid), 64'(0));
    check("midrst result", 64'(result), 64'(0));
    check("midrst ready", 64'(div_ready), 64'(1));
    check("midrst busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: second DIV accepted on the closing edge of the first strobe.
    operand_a = 32'd100; operand_b = 32'd7; div_op = DIV; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b first latency", 64'(lat), 64'(34));
    check("b2b first result", 64'(result), 64'(14));
    check("b2b strobe ready", 64'(div_ready), 64'(1));
    operand_a = 32'hFFFFFF9C; operand_b = 32'd7; div_op = DIV; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    check("b2b accepted busy", 64'(busy), 64'(1));
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b second latency", 64'(lat), 64'(34));
    check("b2b second result", 64'(result), 64'(32'hFFFFFFF2));
    @(posedge clk); #1;

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic [3:0]  op;
      op = 4'(4'b1100 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 11));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = b >> $urandom_range(0, 31);
        1: b = 32'h0;
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: a = a >> $urandom_range(8, 31);
        4: b = 32'(-int'($urandom_range(1, 1000)));
        default: ;
      endcase
      run_op(a, b, op, ref_model(a, b, op), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divider_iter.md
# divider_iter

Parametrised multi-cycle radix-2 restoring divider for the M extension: DIV, DIVU, REM and REMU. It sits beside the ALU in the EX stage and replaces the single-cycle combinational divider. It uses a valid/ready request handshake, a one-cycle result strobe, and a kill input for pipeline flushes. The operand width is a parameter, and special cases follow the RISC-V divide-by-zero and overflow rules.

## Interface
- XLEN, 32: operand and result width; must be at least 4.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- operand_a_i  in  XLEN  dividend (rs1).
- operand_b_i  in  XLEN  divisor (rs2).
- div_op_i  in  4  operation select:
  - 1100 DIV
  - 1101 DIVU
  - 1110 REM
  - 1111 REMU
- div_valid_i  in  1  request valid.
- div_ready_o  out  1  idle and able to accept a request; 1 after reset.
- kill_i  in  1  abort the request in flight (pipeline flush).
- result_o  out  XLEN  result; holds its value until the next result strobe; reset 0.
- result_valid_o  out  1  one-cycle result strobe; reset 0.
- busy_o  out  1  operation in flight (equals ~div_ready_o); reset 0.

## Operation
- Request accept: div_valid_i & div_ready_o & ~kill_i on a rising edge. The block latches the operands and the op.
- States:
  - IDLE: wait for a request; on accept go to PREP.
  - PREP: compute absolute values for signed ops; flag divide-by-zero (b==0) and signed overflow (a==2^(XLEN-1), b==all-ones). Clear the count. Go to CALC.
  - CALC: XLEN iterations, one quotient bit per cycle. The remainder is shifted left and the next dividend MSB is shifted in; an XLEN+1-bit trial subtract of the divisor follows. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore. After XLEN cycles go to FIX.
  - FIX: apply signs and special cases, write result_o, set result_valid_o, return to IDLE.
- Sign rules:
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the dividend's sign.
- Special cases, applied in FIX and overriding the datapath:
  - Divide-by-zero: quotient = all-ones; remainder = operand_a.
  - Signed overflow: quotient = operand_a; remainder = 0.
- Unrecognised div_op_i: accepted normally, result_o = 0.
- Kill:
  - kill_i in any non-IDLE state: next state is IDLE, no result strobe, result_o unchanged.
  - kill_i together with div_valid_i in IDLE: the request is discarded.
- Reset mid-operation: next state is IDLE; all outputs take their reset values; internal datapath registers may hold stale values.

## Timing
- Accept on edge 0 without DIV_EARLY_OUT_EN:
  - PREP runs in cycle 1.
  - CALC runs in cycles 2..XLEN+1.
  - FIX edge is XLEN+2; result_valid_o is high for the cycle after that edge (latency 34 for XLEN=32).
- Latency is fixed, special cases included, unless the macro is set.
- div_ready_o is 1 during the strobe cycle. A back-to-back accept on the strobe cycle's closing edge is legal and gives zero bubble.
- result_valid_o and result_o are registered; no combinational path from any input to any output except div_ready_o, which is decoded from state only.
- No output backpressure: the consumer must take the result during the strobe cycle.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - These cases skip CALC, going PREP→FIX, with result_valid_o 2 cycles after accept:
    - divide-by-zero
    - signed overflow
    - |a| < |b| (quotient 0, remainder = operand_a)
  - All other operations keep full latency.
- DIV_EARLY_OUT_EN undefined: every operation takes exactly XLEN+2 cycles. No early-out comparator is built.

## Structure
- Shared defines header holds:
  - The ALU_OP_DIV/DIVU/REM/REMU codes, shared with the ALU and decoder and guarded against double definition.
  - The state encoding localparams, IDLE/PREP/CALC/FIX.
- Sub-module div_restore_step: combinational single-iteration step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder and quotient bit.
  - Parametrised by XLEN; reusable for a future radix-4 unrolled variant.
- Top level holds:
  - the FSM;
  - the log2(XLEN)+1-bit iteration counter;
  - the operand, quotient and remainder registers;
  - the sign/fix logic.

## Test plan
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF. result_valid_o exactly 34 cycles after accept; one-cycle strobe.
- DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF; REMU → 0x0000000F.
- DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5. Latency 34 without the macro, 2 with DIV_EARLY_OUT_EN.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- kill_i on the 10th CALC cycle:
  - no strobe; result_o keeps its previous value; div_ready_o is 1 the next cycle;
  - a following DIVU 100/7 → 14.
- Reset asserted mid-CALC: outputs go to reset values on that edge. After reset a DIV issued in the strobe cycle of a prior DIV 100/7 (back-to-back) gives both results, 14 then the new one, with no lost request.
